fx_pt_add_arb: RTL and testbench

Round-robin arbiter and pipeline controller that shares one rounding fixed-point adder datapath among `NREQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, pushes its operands through a two-stage registered add-and-round pipeline, and returns the rounded sum tagged with the requester index. It sits between the requesting filter lanes and the shared `fx_pt_add_rnd` arithmetic, replacing per-lane adder instances.

---
 rtl/fx_pt_add_arb.sv | 141 ++++++++++++++
 tb/tb_fx_pt_add_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_pt_add_arb.sv
// fx_pt_add_arb -- shares one rounding fixed-point adder among NREQ requesters.
//
// A round-robin arbiter grants one requester per cycle. The granted operands go
// through a two-stage registered pipeline: stage 1 holds the operands, and stage 2
// holds the rounded sum. The result is tagged with the index of its requester.
//
// Configuration macro: FX_PT_ADD_ARB_FIXPRI_EN
//   - Defined: fixed priority. The lowest index wins and there is no rotating pointer.
//   - Undefined (default): round-robin.
//
// Ports:
//   clk      in   clock; all state changes on the rising edge
//   rst      in   synchronous, active-high reset
//   req_vld  in   [NREQ]           per-requester operand valid
//   req_a    in   [NREQ*(AIW+AFW)] packed operand a, requester i in slice i
//   req_b    in   [NREQ*(BIW+BFW)] packed operand b, requester i in slice i
//   req_rdy  out  [NREQ]           one-hot-or-zero grant (combinational)
//   out_vld  out  result valid
//   out_sum  out  [SIW+SFW]        rounded sum
//   out_id   out  [IDW]            requester index owning out_sum
//   out_rdy  in   downstream accepts the result
module fx_pt_add_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int SN   = 1,
   parameter int AIW  = 9,
   parameter int AFW  = 8,
   parameter int BIW  = 10,
   parameter int BFW  = 9,
   parameter int SIW  = ((AIW > BIW) ? AIW : BIW) + 2,
   parameter int SFW  = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_vld,
   input  logic [NREQ*(AIW+AFW)-1:0]   req_a,
   input  logic [NREQ*(BIW+BFW)-1:0]   req_b,
   output logic [NREQ-1:0]             req_rdy,
   output logic                        out_vld,
   output logic [SIW+SFW-1:0]          out_sum,
   output logic [IDW-1:0]              out_id,
   input  logic                        out_rdy
);

   localparam int AW  = AIW + AFW;
   localparam int BW  = BIW + BFW;
   localparam int SW  = SIW + SFW;
   localparam int F   = (AFW > BFW) ? AFW : BFW;
   // One guard bit above SIW+F so that the rounding increment cannot wrap.
   localparam int WX  = SIW + F + 1;
   localparam bit SGN = (SN != 0);

   logic            adv;
   logic            found;
   logic            acc;
   logic [IDW-1:0]  base;
   logic [IDW-1:0]  gid;
   int              idx;

   logic            s1_vld_q;
   logic [IDW-1:0]  s1_id_q;
   logic [AW-1:0]   s1_a_q;
   logic [BW-1:0]   s1_b_q;
   logic            out_vld_q;
   logic [IDW-1:0]  out_id_q;
   logic [SW-1:0]   out_sum_q;
   logic [SW-1:0]   sum_d;

   assign adv = !out_vld_q || out_rdy;

`ifdef FX_PT_ADD_ARB_FIXPRI_EN
   assign base = '0;
`else
   logic [IDW-1:0] ptr_q, ptr_d;
   assign base  = ptr_q;
   assign ptr_d = acc ? IDW'((int'(gid) + 1) % NREQ) : ptr_q;

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   // Find the first valid requester at or above base, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      gid   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(base) + k) % NREQ;
         if (!found && req_vld[idx]) begin
            found = 1'b1;
            gid   = IDW'(idx);
         end
      end
   end

   assign acc     = found && adv && !rst;
   assign req_rdy = acc ? (NREQ'(1) << gid) : '0;

   // Align to F fraction bits and extend to SIW integer bits (plus guard).
   logic signed [WX-1:0] ax, bx, sx;
   assign ax = $signed({{(WX-AW){SGN & s1_a_q[AW-1]}}, s1_a_q}) <<< (F - AFW);
   assign bx = $signed({{(WX-BW){SGN & s1_b_q[BW-1]}}, s1_b_q}) <<< (F - BFW);
   assign sx = ax + bx;

   generate
      if (F > SFW) begin : g_rnd
         // Add half an output LSB, then floor-shift: round half toward +inf.
         localparam logic signed [WX-1:0] HALF = WX'(1) << (F - SFW - 1);
         assign sum_d = SW'((sx + HALF) >>> (F - SFW));
      end else begin : g_shl
         assign sum_d = SW'(sx) << (SFW - F);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_id_q   <= '0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         out_vld_q <= 1'b0;
         out_id_q  <= '0;
         out_sum_q <= '0;
      end else if (adv) begin
         s1_vld_q  <= acc;
         s1_id_q   <= gid;
         s1_a_q    <= req_a[gid*AW +: AW];
         s1_b_q    <= req_b[gid*BW +: BW];
         out_vld_q <= s1_vld_q;
         out_id_q  <= s1_id_q;
         out_sum_q <= sum_d;
      end
   end

   assign out_vld = out_vld_q;
   assign out_id  = out_id_q;
   assign out_sum = out_sum_q;

endmodule

// File: tb/tb_fx_pt_add_arb.sv
// Self-checking bench for fx_pt_add_arb (default parameters).
// A queue-based reference tracks accepted operations and their ages in the pipeline.
// It predicts the grants and the outputs on every cycle. Directed sections pin the
// literal behaviour, and a randomized phase follows.
module tb_fx_pt_add_arb;
   localparam int NREQ = 4, IDW = 2, SN = 1, AIW = 9, AFW = 8, BIW = 10, BFW = 9;
   localparam int SIW = 12, SFW = 7;
   localparam int AW = AIW + AFW, BW = BIW + BFW, SW = SIW + SFW;
   localparam int F = (AFW > BFW) ? AFW : BFW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_vld;
   logic [NREQ*AW-1:0]    req_a;
   logic [NREQ*BW-1:0]    req_b;
   logic [NREQ-1:0]       req_rdy;
   logic                  out_vld;
   logic [SW-1:0]         out_sum;
   logic [IDW-1:0]        out_id;
   logic                  out_rdy;

   fx_pt_add_arb #(
      .NREQ(NREQ), .IDW(IDW), .SN(SN), .AIW(AIW), .AFW(AFW),
      .BIW(BIW), .BFW(BFW), .SIW(SIW), .SFW(SFW)
   ) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
      .req_rdy(req_rdy), .out_vld(out_vld), .out_sum(out_sum), .out_id(out_id),
      .out_rdy(out_rdy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Exact real-valued sum on a 2^-F grid, then round half up to SFW bits.
   function automatic logic [SW-1:0] mdl(input logic [AW-1:0] a, input logic [BW-1:0] b);
      longint sa, sb, s;
      sa = longint'(a);
      if (SN != 0 && a[AW-1]) sa = sa - (longint'(1) << AW);
      sb = longint'(b);
      if (SN != 0 && b[BW-1]) sb = sb - (longint'(1) << BW);
      s = sa * (longint'(1) << (F - AFW)) + sb * (longint'(1) << (F - BFW));
      if (F > SFW) s = (s + (longint'(1) << (F - SFW - 1))) >>> (F - SFW);
      else         s = s * (longint'(1) << (SFW - F));
      return s[SW-1:0];
   endfunction

   typedef struct {
      logic [SW-1:0]  sum;
      logic [IDW-1:0] id;
      int             age;   // 1 = in operand stage, 2 = at the output
   } ent_t;

   ent_t q[$];
   int   mptr  = 0;
   bit   armed = 1'b0;

   always @(negedge clk) begin : cmp
      bit              ev;
      bit              madv;
      int              g;
      int              i;
      logic [NREQ-1:0] er;
      ent_t            e;
      ev = (q.size() > 0) && (q[0].age == 2);
      if (armed) begin
         chk("out_vld", out_vld, ev);
         if (ev) begin
            chk("out_sum", out_sum, q[0].sum);
            chk("out_id", out_id, q[0].id);
         end
      end
      madv = !ev || out_rdy;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef FX_PT_ADD_ARB_FIXPRI_EN
         i = k;
`else
         i = (mptr + k) % NREQ;
`endif
         if (g < 0 && req_vld[i]) g = i;
      end
      er = '0;
      if (!rst && madv && g >= 0) er[g] = 1'b1;
      if (armed) chk("req_rdy", req_rdy, er);
      if (rst) begin
         q.delete();
         mptr = 0;
      end else if (madv) begin
         if (ev) void'(q.pop_front());
         foreach (q[j]) q[j].age++;
         if (g >= 0) begin
            e.sum = mdl(req_a[g*AW +: AW], req_b[g*BW +: BW]);
            e.id  = IDW'(g);
            e.age = 1;
            q.push_back(e);
            mptr = (g + 1) % NREQ;
         end
      end
   end

   logic [NREQ-1:0] acc_last;

   task automatic sample();
      @(negedge clk); #1;
      acc_last = req_vld & req_rdy;
   endtask

   task automatic nextc();
      @(posedge clk); #1;
   endtask

   function automatic logic [AW-1:0] rnd_a();
      case ($urandom % 6)
         0: return '0;
         1: return {AW{1'b1}};
         2: return {1'b1, {(AW-1){1'b0}}};
         3: return {1'b0, {(AW-1){1'b1}}};
         default: return AW'($urandom);
      endcase
   endfunction

   function automatic logic [BW-1:0] rnd_b();
      case ($urandom % 6)
         0: return '0;
         1: return {BW{1'b1}};
         2: return {1'b1, {(BW-1){1'b0}}};
         3: return {1'b0, {(BW-1){1'b1}}};
         default: return BW'($urandom);
      endcase
   endfunction

   // Re-present or drop each requester that was accepted in the last cycle.
   task automatic reload(input bit keep);
      for (int i = 0; i < NREQ; i++) begin
         if (acc_last[i]) begin
            if (keep || ($urandom % 2 == 0)) begin
               req_a[i*AW +: AW] = rnd_a();
               req_b[i*BW +: BW] = rnd_b();
               req_vld[i] = 1'b1;
            end else begin
               req_vld[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic one_op(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [SW-1:0] e);
      int n;
      n = 0;
      req_a[id*AW +: AW] = a;
      req_b[id*BW +: BW] = b;
      req_vld[id] = 1'b1;
      sample();
      while (!acc_last[id] && n < 8) begin
         nextc(); sample(); n++;
      end
      chk("op_grant", acc_last[id], 1'b1);
      nextc();
      req_vld[id] = 1'b0;
      sample(); nextc();
      sample();
      chk("op_vld", out_vld, 1'b1);
      chk("op_sum", out_sum, e);
      chk("op_id", out_id, id);
      nextc();
   endtask

   initial begin
      logic [NREQ-1:0] eg;
      rst = 1'b1; req_vld = '0; req_a = '0; req_b = '0; out_rdy = 1'b1; acc_last = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_vld", out_vld, 1'b0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_id", out_id, 0);
      rst = 1'b0;
      armed = 1'b1;

      // Literal pins of the reference arithmetic.
      chk("pin_add", mdl(17'h00180, 19'h00480), 19'h001E0);
      chk("pin_up", mdl(17'h00001, 19'h0), 19'h00001);
      chk("pin_m1", mdl(17'h1FFFF, 19'h0), 19'h00000);
      chk("pin_m2", mdl(17'h1FFFE, 19'h0), 19'h7FFFF);

      // Single add, latency of two cycles.
      req_a[0 +: AW] = 17'h00180; req_b[0 +: BW] = 19'h00480; req_vld = 4'b0001;
      sample(); chk("single_rdy", req_rdy, 4'b0001); nextc();
      req_vld = '0;
      sample(); chk("single_vld_n1", out_vld, 1'b0); nextc();
      sample();
      chk("single_vld", out_vld, 1'b1);
      chk("single_sum", out_sum, 19'h001E0);
      chk("single_id", out_id, 0);
      nextc();

      // Rounding and range corners.
      one_op(0, 17'h00001, 19'h00000, 19'h00001);
      one_op(2, 17'h1FFFF, 19'h00000, 19'h00000);
      one_op(3, 17'h1FFFE, 19'h00000, 19'h7FFFF);
      one_op(1, 17'h0FFFF, 19'h3FFFF, 19'h17FFF);
      one_op(1, 17'h00000, 19'h40000, 19'h70000);

      // Round-robin fairness from reset.
      rst = 1'b1;
      sample(); chk("rst_rdy", req_rdy, 0); nextc();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*AW +: AW] = rnd_a(); req_b[i*BW +: BW] = rnd_b();
      end
      req_vld = '1;
      for (int k = 0; k < 6; k++) begin
         sample();
`ifdef FX_PT_ADD_ARB_FIXPRI_EN
         chk("rr_gnt", req_rdy, 4'b0001);
         if (k >= 2) chk("rr_id", out_id, 0);
`else
         eg = NREQ'(1) << (k % NREQ);
         chk("rr_gnt", req_rdy, eg);
         if (k >= 2) chk("rr_id", out_id, (k - 2) % NREQ);
`endif
         nextc(); reload(1'b1);
      end

      // Backpressure with a full pipeline.
      out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("bp_rdy", req_rdy, 0);
         chk("bp_vld", out_vld, 1'b1);
         nextc(); reload(1'b1);
      end
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample(); nextc(); reload(1'b1);
      end

      // Reset with two results in flight.
      rst = 1'b1;
      sample(); chk("mid_rst_rdy", req_rdy, 0); nextc();
      rst = 1'b0; reload(1'b1);
      sample();
      chk("mid_rst_vld", out_vld, 1'b0);
      chk("mid_rst_gnt", req_rdy, 4'b0001);
      nextc(); reload(1'b1);

`ifdef FX_PT_ADD_ARB_FIXPRI_EN
      rst = 1'b1; req_vld = 4'b1010;
      sample(); nextc();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample(); chk("fp_gnt1", req_rdy, 4'b0010); nextc(); reload(1'b1);
      end
      req_vld[1] = 1'b0;
      sample(); chk("fp_gnt3", req_rdy, 4'b1000); nextc(); reload(1'b0);
`endif

      // Randomized traffic, backpressure and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_vld[i] && ($urandom % 3 == 0)) begin
               req_a[i*AW +: AW] = rnd_a(); req_b[i*BW +: BW] = rnd_b();
               req_vld[i] = 1'b1;
            end
         end
         out_rdy = ($urandom % 4) != 0;
         rst = ($urandom % 300) == 0;
         sample(); nextc(); reload(1'b0);
      end

      rst = 1'b0; out_rdy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         sample(); nextc(); reload(1'b0);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
